tpu_result_writer: RTL and testbench

- Downstream of the TPU system. Consumes the four normalized bottom-row outputs (PE(3,0)..PE(3,3)) when the array signals done.
- Clamps each output to an 8-bit pixel and writes the four pixels, one per accepted cycle, into the output frame memory at an auto-incrementing address.
- Tracks frame completion and saturation statistics for the brightness-filter pipeline.

---
 rtl/tpu_result_writer_if.sv | 29 ++
 rtl/tpu_result_writer.sv | 153 +++++++++++++++
 tb/tb_tpu_result_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tpu_result_writer_if.sv
// Result/write-port bundle for tpu_result_writer.
// The master side supplies the bottom-row results and the memory's wr_ready.
// The slave side (the writer) returns result_ready and drives the write request.
interface tpu_result_writer_if #(
    parameter int NORM_W = 16,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
);
    logic              result_valid;
    logic [NORM_W-1:0] pe30_norm_in;
    logic [NORM_W-1:0] pe31_norm_in;
    logic [NORM_W-1:0] pe32_norm_in;
    logic [NORM_W-1:0] pe33_norm_in;
    logic              result_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;

    modport master (
        output result_valid, pe30_norm_in, pe31_norm_in, pe32_norm_in, pe33_norm_in, wr_ready,
        input  result_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  result_valid, pe30_norm_in, pe31_norm_in, pe32_norm_in, pe33_norm_in, wr_ready,
        output result_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/tpu_result_writer.sv
// TPU result writer: clamps the four bottom-row PE results to pixels and
// streams them, one per accepted cycle, into frame memory at an auto-
// incrementing address, with frame-done and saturation tracking.

// Per-lane clamp of a signed normalized value into the unsigned pixel range.
module tpu_rw_clamp #(
    parameter int NORM_W = 16,
    parameter int PIX_W  = 8
) (
    input  logic [NORM_W-1:0] din,
    output logic [PIX_W-1:0]  pix,
    output logic              sat
);
    localparam logic [NORM_W-1:0] PIX_MAX = NORM_W'((1 << PIX_W) - 1);

    // Negative floors at 0, anything past full scale pins to full scale
    always_comb begin
        pix = din[PIX_W-1:0];
        sat = 1'b0;
        if (din[NORM_W-1]) begin
            pix = '0;
            sat = 1'b1;
        end else if (din > PIX_MAX) begin
            pix = '1;
            sat = 1'b1;
        end
    end
endmodule

module tpu_result_writer #(
    parameter int NORM_W       = 16,
    parameter int PIX_W        = 8,
    parameter int ADDR_W       = 10,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    tpu_result_writer_if.slave   bus,
    input  logic                 frame_clear,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          sat_count,
    output logic                 drop_err
);
    localparam int NUM_LANES = 4;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + FRAME_PIXELS - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                              state, state_nxt;
    logic [ADDR_W-1:0]                   addr;
    logic [1:0]                          lane;
    logic [NUM_LANES-1:0][NORM_W-1:0]    lane_in;
    logic [NUM_LANES-1:0][PIX_W-1:0]     pix;
    logic [NUM_LANES-1:0][PIX_W-1:0]     cap;
    logic [NUM_LANES-1:0]                sat;
    logic                                capture, accept, clear;
    logic [2:0]                          sat_inc;
    logic [15:0]                         sat_base;
    logic [16:0]                         sat_sum;
    logic [15:0]                         sat_next;

    assign lane_in = {bus.pe33_norm_in, bus.pe32_norm_in, bus.pe31_norm_in, bus.pe30_norm_in};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tpu_rw_clamp #(.NORM_W(NORM_W), .PIX_W(PIX_W)) u_clamp (
            .din (lane_in[g]),
            .pix (pix[g]),
            .sat (sat[g])
        );
    end

    assign bus.wr_addr = addr;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the handshake and write-port outputs
    always_comb begin
        state_nxt        = state;
        bus.result_ready = 1'b0;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        busy             = 1'b0;
        capture          = 1'b0;
        accept           = 1'b0;
        case (state)
            IDLE: begin
                bus.result_ready = 1'b1;
                if (bus.result_valid) begin
                    capture   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_data = cap[lane];
                if (bus.wr_ready) begin
                    accept = 1'b1;
                    if (lane == 2'd3) state_nxt = IDLE;
                end
            end
        endcase
    end

    // Saturation tally for the incoming set; a same-cycle clear zeroes the base first
    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) sat_inc = sat_inc + {2'b00, sat[i]};
        clear    = (state == IDLE) && frame_clear;
        sat_base = clear ? 16'd0 : sat_count;
        sat_sum  = {1'b0, sat_base} + {14'd0, sat_inc};
        sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // Capture, address/lane sequencing, and the single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= BASE;
            lane       <= 2'd0;
            cap        <= '0;
            sat_count  <= '0;
            frame_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            drop_err   <= bus.result_valid && !bus.result_ready;
            if (clear) addr <= BASE;
            if (capture) begin
                cap       <= pix;
                lane      <= 2'd0;
                sat_count <= sat_next;
            end else if (clear) begin
                sat_count <= '0;
            end
            if (accept) begin
                lane <= lane + 2'd1;
                if (addr == LAST) begin
                    addr       <= BASE;
                    frame_done <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tpu_result_writer.sv
// Directed, table-driven bench for tpu_result_writer with an 8-pixel frame.
module tb_tpu_result_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        frame_clear;
    logic        busy, frame_done, drop_err;
    logic [15:0] sat_count;

    tpu_result_writer_if #(.NORM_W(16), .PIX_W(8), .ADDR_W(10)) bus ();

    tpu_result_writer #(
        .NORM_W(16), .PIX_W(8), .ADDR_W(10), .BASE_ADDR(0), .FRAME_PIXELS(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .frame_clear (frame_clear),
        .busy        (busy),
        .frame_done  (frame_done),
        .sat_count   (sat_count),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] din;
        logic [3:0][7:0]  pix;
        int               nsat;
        logic             clr;
        int               stall_lane;
        int               drop_lane;
    } vec_t;

    vec_t tbl[9];
    int   total = 0;
    int   passed = 0;
    int   m_addr = 0;
    int   m_sat = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0][15:0] d);
        bus.pe30_norm_in = d[0];
        bus.pe31_norm_in = d[1];
        bus.pe32_norm_in = d[2];
        bus.pe33_norm_in = d[3];
    endtask

    task automatic write_set(input string tag, input vec_t v);
        logic fd;
        logic dexp;
        chk({tag, " ready_idle"}, 32'(bus.result_ready), 32'd1);
        drive(v.din);
        frame_clear      = v.clr;
        bus.result_valid = 1'b1;
        tick;
        bus.result_valid = 1'b0;
        frame_clear      = 1'b0;
        drive({4{16'h0010}});
        if (v.clr) begin
            m_addr = 0;
            m_sat  = 0;
        end
        m_sat = (m_sat + v.nsat > 65535) ? 65535 : m_sat + v.nsat;
        fd   = 1'b0;
        dexp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, " wr_en"},    32'(bus.wr_en), 32'd1);
            chk({tag, " busy"},     32'(busy), 32'd1);
            chk({tag, " ready_bsy"}, 32'(bus.result_ready), 32'd0);
            chk({tag, " wr_addr"},  32'(bus.wr_addr), 32'(m_addr));
            chk({tag, " wr_data"},  32'(bus.wr_data), 32'(v.pix[k]));
            chk({tag, " drop_err"}, 32'(drop_err), 32'(dexp));
            chk({tag, " sat"},      32'(sat_count), 32'(m_sat));
            if (k == v.stall_lane) begin
                bus.wr_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick;
                    chk({tag, " stall_en"},   32'(bus.wr_en), 32'd1);
                    chk({tag, " stall_addr"}, 32'(bus.wr_addr), 32'(m_addr));
                    chk({tag, " stall_data"}, 32'(bus.wr_data), 32'(v.pix[k]));
                end
                bus.wr_ready = 1'b1;
            end
            dexp = 1'b0;
            if (k == v.drop_lane) bus.result_valid = 1'b1;
            tick;
            bus.result_valid = 1'b0;
            if (k == v.drop_lane) dexp = 1'b1;
            fd     = (m_addr == 7);
            m_addr = (m_addr == 7) ? 0 : m_addr + 1;
        end
        chk({tag, " ready_end"}, 32'(bus.result_ready), 32'd1);
        chk({tag, " wr_en_end"}, 32'(bus.wr_en), 32'd0);
        chk({tag, " busy_end"},  32'(busy), 32'd0);
        chk({tag, " addr_end"},  32'(bus.wr_addr), 32'(m_addr));
        chk({tag, " fdone"},     32'(frame_done), 32'(fd));
        chk({tag, " drop_end"},  32'(drop_err), 32'(dexp));
        tick;
        chk({tag, " fdone_off"}, 32'(frame_done), 32'd0);
        chk({tag, " drop_off"},  32'(drop_err), 32'd0);
        chk({tag, " no_write"},  32'(bus.wr_en), 32'd0);
    endtask

    initial begin
        vec_t v0;
        tbl[0] = '{{16'hFFF6, 16'h0100, 16'h00FF, 16'd100}, {8'd0, 8'd255, 8'd255, 8'd100}, 2, 1'b1, -1, -1};
        tbl[1] = '{{16'hFFF6, 16'h0100, 16'h00FF, 16'd100}, {8'd0, 8'd255, 8'd255, 8'd100}, 2, 1'b1,  1, -1};
        tbl[2] = '{{16'hFFF6, 16'h0100, 16'h00FF, 16'd100}, {8'd0, 8'd255, 8'd255, 8'd100}, 2, 1'b1, -1,  1};
        tbl[3] = '{{16'h8000, 16'h7FFF, 16'h0001, 16'h0000}, {8'd0, 8'd255, 8'd1, 8'd0},     2, 1'b1, -1, -1};
        tbl[4] = '{{16'h0101, 16'h0200, 16'h0080, 16'h00FE}, {8'd255, 8'd255, 8'd128, 8'd254}, 2, 1'b1, -1, -1};
        tbl[5] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {8'd0, 8'd0, 8'd0, 8'd0},       4, 1'b0, -1, -1};
        tbl[6] = '{{16'd8, 16'd7, 16'd6, 16'd5},             {8'd8, 8'd7, 8'd6, 8'd5},       0, 1'b0, -1,  3};
        tbl[7] = '{{16'd3, 16'd2, 16'd1, 16'h1000},          {8'd3, 8'd2, 8'd1, 8'd255},     1, 1'b0, -1, -1};
        tbl[8] = '{{16'hFFF0, 16'd9, 16'd9, 16'd9},          {8'd0, 8'd9, 8'd9, 8'd9},       1, 1'b0, -1, -1};

        reset            = 1'b0;
        frame_clear      = 1'b0;
        bus.result_valid = 1'b0;
        bus.wr_ready     = 1'b1;
        drive({4{16'h0000}});
        tick;
        tick;
        chk("rst ready",  32'(bus.result_ready), 32'd1);
        chk("rst wr_en",  32'(bus.wr_en), 32'd0);
        chk("rst addr",   32'(bus.wr_addr), 32'd0);
        chk("rst data",   32'(bus.wr_data), 32'd0);
        chk("rst busy",   32'(busy), 32'd0);
        chk("rst fdone",  32'(frame_done), 32'd0);
        chk("rst sat",    32'(sat_count), 32'd0);
        chk("rst drop",   32'(drop_err), 32'd0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 9; i++) write_set($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a write burst, after lanes 0 and 1 are accepted
        drive(tbl[0].din);
        bus.result_valid = 1'b1;
        tick;
        bus.result_valid = 1'b0;
        chk("midrst lane0 addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("midrst sat",        32'(sat_count), 32'(m_sat + 2));
        tick;
        chk("midrst lane1 addr", 32'(bus.wr_addr), 32'(m_addr + 1));
        chk("midrst lane1 data", 32'(bus.wr_data), 32'd255);
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("midrst wr_en", 32'(bus.wr_en), 32'd0);
        chk("midrst addr",  32'(bus.wr_addr), 32'd0);
        chk("midrst sat0",  32'(sat_count), 32'd0);
        chk("midrst busy",  32'(busy), 32'd0);
        chk("midrst ready", 32'(bus.result_ready), 32'd1);
        tick;
        chk("midrst idle", 32'(bus.wr_en), 32'd0);
        m_addr = 0;
        m_sat  = 0;
        v0 = tbl[0];
        v0.clr = 1'b0;
        write_set("postrst", v0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
